// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, framing-error and overrun pulses.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic             rx_meta;
    logic             rxs;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             half_hit;
    logic             full_hit;

    logic             cnt_clr_c;
    logic             idx_clr_c;
    logic             shift_en_c;
    logic             load_c;
    logic             ferr_c;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             par_chk_c;
    logic             par_err_c;

    assign par_err_c = ^{shift_q, rxs};
`endif

    assign half_hit = (cnt_q == HALF_M1);
    assign full_hit = (cnt_q == FULL_M1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rxs) state_d = START;
            START:     if (half_hit) state_d = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (full_hit && idx_q == 3'd7) state_d = PARITY;
            PARITY:    if (full_hit) state_d = STOP;
`else
            DATA:      if (full_hit && idx_q == 3'd7) state_d = STOP;
`endif
            // Return to IDLE mid stop bit so an immediately following start bit is caught
            STOP:      if (full_hit) state_d = rxs ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath
    always_comb begin
        cnt_clr_c  = 1'b0;
        idx_clr_c  = 1'b0;
        shift_en_c = 1'b0;
        load_c     = 1'b0;
        ferr_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk_c  = 1'b0;
`endif
        case (state_q)
            IDLE, WAIT_IDLE: cnt_clr_c = 1'b1;
            START: begin
                if (half_hit) begin
                    cnt_clr_c = 1'b1;
                    idx_clr_c = 1'b1;
                end
            end
            DATA: begin
                if (full_hit) begin
                    cnt_clr_c  = 1'b1;
                    shift_en_c = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_hit) begin
                    cnt_clr_c = 1'b1;
                    par_chk_c = 1'b1;
                    ferr_c    = par_err_c;
                end
            end
`endif
            STOP: begin
                if (full_hit) begin
                    cnt_clr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
                    load_c    = rxs & ~par_bad_q;
`else
                    load_c    = rxs;
`endif
                    ferr_c    = ~rxs;
                end
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    // Synchroniser, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            cnt_q   <= cnt_clr_c ? '0 : cnt_q + CNT_W'(1);
            if (idx_clr_c) begin
                idx_q <= 3'd0;
            end else if (shift_en_c) begin
                idx_q <= idx_q + 3'd1;
            end
            if (shift_en_c) begin
                shift_q[idx_q] <= rxs;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Remembers a parity failure so the stop bit does not deliver the byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
        end else if (idx_clr_c) begin
            par_bad_q <= 1'b0;
        end else if (par_chk_c) begin
            par_bad_q <= par_err_c;
        end
    end
`endif

    // Consumer-facing registers; a load wins over a simultaneous ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_c;
            overrun   <= load_c & valid & ~ack;
            if (load_c) begin
                data_out <= shift_q;
                valid    <= 1'b1;
            end else if (ack) begin
                valid    <= 1'b0;
            end
        end
    end

endmodule
